// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: write-side upsizer in the wclk domain, placed directly ahead of
// the async FIFO. It packs OUT_WIDTH/IN_WIDTH narrow beats into one FIFO word,
// little-endian by lane. A packet whose s_last arrives early is flushed with the
// unwritten lanes zero-filled.
// Optional feature, enabled by defining PACK_FLUSH_TIMEOUT_EN: a partial word that
// sits idle for FLUSH_TIMEOUT cycles is flushed automatically.
module fifo_wr_packer #(
    parameter int unsigned IN_WIDTH      = 8,
    parameter int unsigned OUT_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned FLUSH_TIMEOUT = 16
) (
    input  logic                 wclk,
    input  logic                 rrst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    input  logic                 fifo_full,
    output logic                 fifo_w_en,
    output logic [OUT_WIDTH-1:0] fifo_data,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int unsigned RATIO    = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Reject parameter sets that cannot describe a valid upsizer
    generate
        if ((OUT_WIDTH % IN_WIDTH) != 0 || RATIO < 2 || FLUSH_TIMEOUT == 0) begin : g_bad_params
            $error("fifo_wr_packer: illegal parameter combination");
        end
    endgenerate

    logic [IDX_W-1:0]     r_idx;
    logic [OUT_WIDTH-1:0] r_asm;
    logic                 r_out_valid;
    logic [OUT_WIDTH-1:0] r_fifo_data;
    logic [CNT_WIDTH-1:0] r_word_cnt;

    logic                 w_out_free;
    logic                 w_accept;
    logic                 w_complete;
    logic                 w_fifo_w_en;
    logic                 w_flush;
    logic [OUT_WIDTH-1:0] w_merged;

    // The output slot can take a new word if it is empty or drains this cycle
    assign w_out_free  = !r_out_valid || !fifo_full;
    assign w_accept    = s_valid && w_out_free;
    assign w_fifo_w_en = r_out_valid && !fifo_full;
    assign w_complete  = w_accept && ((r_idx == LAST_IDX) || s_last);

    // Assembly register with the incoming beat dropped into the current lane
    always_comb begin
        w_merged = r_asm;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_merged[k*IN_WIDTH +: IN_WIDTH] = s_data;
            end
        end
    end

`ifdef PACK_FLUSH_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(FLUSH_TIMEOUT + 1);

    logic [TMR_W-1:0] r_tmr;
    logic             w_tmr_hit;

    assign w_tmr_hit = (r_tmr == TMR_W'(FLUSH_TIMEOUT));
    // A beat accepted in the same cycle wins over the timeout flush
    assign w_flush   = w_tmr_hit && w_out_free && !w_accept && (r_idx != '0);

    // Idle timer: counts while a partial word waits, saturates at the limit
    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_tmr <= '0;
        end else if (w_accept || w_flush || (r_idx == '0)) begin
            r_tmr <= '0;
        end else if (!w_tmr_hit) begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    // Lane index and assembly register
    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (w_complete || w_flush) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + IDX_W'(1);
            r_asm <= w_merged;
        end
    end

    // Output word register: loaded by a completed or flushed word, emptied by a write
    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_out_valid <= 1'b0;
            r_fifo_data <= '0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_fifo_data <= w_merged;
        end else if (w_flush) begin
            r_out_valid <= 1'b1;
            r_fifo_data <= r_asm;
        end else if (w_fifo_w_en) begin
            r_out_valid <= 1'b0;
        end
    end

    // Count of words handed to the FIFO, free-running and wrapping
    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_word_cnt <= '0;
        end else if (w_fifo_w_en) begin
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        end
    end

    assign s_ready   = w_out_free;
    assign fifo_w_en = w_fifo_w_en;
    assign fifo_data = r_fifo_data;
    assign word_cnt  = r_word_cnt;

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
- Write-side upsizer that sits directly upstream of the asynchronous FIFO, in the wclk domain.
- Accepts narrow IN_WIDTH beats over a valid/ready stream and packs RATIO = OUT_WIDTH/IN_WIDTH beats into one OUT_WIDTH word.
- Drives the FIFO write port (w_en, data_in) and honours its full flag.
- Short packets (s_last before the word is complete) are flushed zero-filled.

Parameters:
- IN_WIDTH, 8, input beat width in bits.
- OUT_WIDTH, 32, FIFO word width in bits; must be an integer multiple of IN_WIDTH, with RATIO >= 2.
- CNT_WIDTH, 16, width of the written-word counter.
- FLUSH_TIMEOUT, 16, idle cycles before a partial word is flushed (used only with the optional feature).

Ports:
- wclk  in  1  write-domain clock; all state is on posedge.
- rrst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  IN_WIDTH  input beat.
- s_last  in  1  final beat of packet; forces a word flush.
- fifo_full  in  1  FIFO full flag.
- fifo_w_en  out  1  FIFO write enable.
- fifo_data  out  OUT_WIDTH  FIFO write data.
- word_cnt  out  CNT_WIDTH  count of words written to the FIFO; wraps.

Behaviour:
- Interface: reset rrst_n, asynchronous, active-low; clock wclk.
- Reset state:
  - Lane index idx = 0, assembly register = 0, out_valid = 0, fifo_data = 0, word_cnt = 0.
  - fifo_w_en and s_ready follow combinationally: fifo_w_en = 0, s_ready = 1.
- Reset mid-word: the partial word and any pending word are discarded; no FIFO write occurs.
- Handshake definitions:
  - out_free = !out_valid || !fifo_full.
  - s_ready = out_free.
  - A beat is accepted when s_valid && s_ready.
  - fifo_w_en = out_valid && !fifo_full.
- Lane order is little-endian: the first beat of a word goes to bits [IN_WIDTH-1:0], beat k goes to bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- Accepted beat with idx < RATIO-1 and s_last = 0: write the lane, idx <= idx+1.
- Accepted beat with idx == RATIO-1 or s_last = 1 (word completes):
  - Completed word (current lane merged, unwritten lanes zero) loads fifo_data; out_valid <= 1.
  - idx <= 0; assembly register cleared.
- Latency: fifo_data/out_valid update on the edge that accepts the completing beat. fifo_w_en asserts in the following cycle if fifo_full = 0.
- Output register on a cycle with fifo_w_en = 1:
  - FIFO consumes fifo_data; word_cnt <= word_cnt+1, wrapping at 2^CNT_WIDTH.
  - If a new word completes on the same edge, it replaces the register and out_valid stays 1.
  - Otherwise out_valid <= 0.
- Back-to-back throughput is one beat per cycle while fifo_full = 0.
- fifo_full high with out_valid = 1:
  - fifo_w_en = 0; fifo_data held stable; s_ready = 0.
  - No state changes except the feature timer.
- fifo_full high with out_valid = 0: s_ready = 1 and assembly continues. A completing beat loads the register and then waits.
- s_valid with s_ready low: beat not consumed; the source holds it.
- s_last on lane 0 produces a word containing only that beat in the low lane.

Optional Feature:
- Macro: PACK_FLUSH_TIMEOUT_EN.
- Defined:
  - An idle counter runs while idx != 0 and no beat is accepted; it clears on any accepted beat or on flush.
  - When the counter equals FLUSH_TIMEOUT and out_free = 1, the partial word (zero-filled) loads fifo_data; out_valid <= 1, idx <= 0, counter <= 0.
  - If out_free = 0 at that point, the counter saturates and the flush waits.
  - An accepted beat in the same cycle takes priority, and the flush is cancelled.
- Not defined:
  - No counter is built; partial words wait indefinitely for further beats or s_last.
  - The FLUSH_TIMEOUT parameter is ignored.

Test Plan:
- Reset then beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles with fifo_full = 0 -> fifo_data = 0x44332211, fifo_w_en high one cycle, one cycle after the 0x44 edge; word_cnt = 1.
- Beats 0xAA, then 0xBB with s_last = 1 -> fifo_data = 0x0000BBAA written once. Next beat 0x01 lands in lane 0.
- Word pending, fifo_full held high for 5 cycles -> s_ready = 0, fifo_w_en = 0, fifo_data stable. Release -> exactly one write, word_cnt increments by 1.
- 8 back-to-back beats 0x01..0x08, fifo_full = 0 -> writes 0x04030201 then 0x08070605 on consecutive-word cadence; s_ready never drops.
- Beats 0x55, 0x66, then rrst_n pulsed low -> no write, outputs at reset values. Next 4 beats form a clean word with 0x55/0x66 absent.
- With PACK_FLUSH_TIMEOUT_EN and FLUSH_TIMEOUT = 16: beat 0x77, then idle -> fifo_data = 0x00000077 loaded after 16 idle cycles and written. Without the macro, no write occurs.
